// File: rtl/mem_stage.sv
// MEM pipeline stage: load/store over a req/ack data-memory handshake with lane
// steering, sign/zero extension, timeout abort and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_pc,
    input  logic [31:0] MEM_instr,
    input  logic [31:0] MEM_alu,
    input  logic [31:0] MEM_rt,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        busy,
    output logic [31:0] MEM_out_WB,
    output logic [31:0] MEM_instr_WB,
    output logic [31:0] MEM_pc_WB,
    output logic        addr_err_WB,
    output logic        bus_err_WB
);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t      state_r, state_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic [5:0]  opcode_s;
    logic        is_load_s, is_store_s, is_mem_s, sign_s, misaligned_s;
    logic [1:0]  size_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic        req_s, busy_s, done_s, abort_s;
    logic [31:0] out_nxt_s, instr_nxt_s, pc_nxt_s;
    logic        addr_err_nxt_s, bus_err_nxt_s;

    // Picks the addressed byte/half out of the read word, little-endian.
    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic sgn,
                                                 input logic [1:0] offs, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{offs, 3'b000} +: 8];
        h = word[{offs[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
            SZ_HALF: r = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
            SZ_WORD: r = word;
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    // Opcode decode and alignment check.
    always_comb begin
        opcode_s   = MEM_instr[31:26];
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        size_s     = SZ_WORD;
        sign_s     = 1'b0;
        case (opcode_s)
            6'b100011: begin is_load_s  = 1'b1; size_s = SZ_WORD; end
            6'b100000: begin is_load_s  = 1'b1; size_s = SZ_BYTE; sign_s = 1'b1; end
            6'b100100: begin is_load_s  = 1'b1; size_s = SZ_BYTE; end
            6'b100001: begin is_load_s  = 1'b1; size_s = SZ_HALF; sign_s = 1'b1; end
            6'b100101: begin is_load_s  = 1'b1; size_s = SZ_HALF; end
            6'b101011: begin is_store_s = 1'b1; size_s = SZ_WORD; end
            6'b101000: begin is_store_s = 1'b1; size_s = SZ_BYTE; end
            6'b101001: begin is_store_s = 1'b1; size_s = SZ_HALF; end
            default:   begin is_load_s  = 1'b0; is_store_s = 1'b0; end
        endcase
        is_mem_s = is_load_s | is_store_s;
        case (size_s)
            SZ_WORD: misaligned_s = is_mem_s & (MEM_alu[1:0] != 2'b00);
            SZ_HALF: misaligned_s = is_mem_s & MEM_alu[0];
            default: misaligned_s = 1'b0;
        endcase
    end

    // Byte-enable and lane-replicated store data; loads reuse the same enables.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = 32'h00000000;
        if (is_mem_s) begin
            case (size_s)
                SZ_WORD: begin be_s = 4'b1111; wdata_s = MEM_rt; end
                SZ_HALF: begin be_s = MEM_alu[1] ? 4'b1100 : 4'b0011; wdata_s = {2{MEM_rt[15:0]}}; end
                SZ_BYTE: begin be_s = 4'b0001 << MEM_alu[1:0]; wdata_s = {4{MEM_rt[7:0]}}; end
                default: begin be_s = 4'b0000; wdata_s = 32'h00000000; end
            endcase
        end else begin
            be_s    = 4'b0000;
            wdata_s = 32'h00000000;
        end
    end

    // Handshake FSM: next state, wait counter, completion and abort.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        req_s       = 1'b0;
        done_s      = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (is_mem_s && !misaligned_s) begin
                    req_s = 1'b1;
                    if (dm_ack) begin
                        done_s = 1'b1;
                    end else begin
                        state_nxt_s = S_WAIT;
                        cnt_nxt_s   = 8'd1;
                    end
                end else begin
                    req_s = 1'b0;
                end
            end
            S_WAIT: begin
                req_s = 1'b1;
                if (dm_ack) begin
                    done_s      = 1'b1;
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = 8'd0;
                end else if (cnt_r == 8'(TIMEOUT)) begin
                    abort_s     = 1'b1;
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = 8'd0;
            end
        endcase
        busy_s = req_s & ~dm_ack & ~abort_s;
    end

    assign dm_req   = req_s & rst;
    assign busy     = busy_s & rst;
    assign dm_we    = is_store_s;
    assign dm_addr  = {MEM_alu[31:2], 2'b00};
    assign dm_be    = be_s;
    assign dm_wdata = wdata_s;

    // Next MEM/WB contents: bubble while stalled, otherwise the retiring instruction.
    always_comb begin
        out_nxt_s      = 32'h00000000;
        instr_nxt_s    = 32'h00000000;
        pc_nxt_s       = 32'h00000000;
        addr_err_nxt_s = 1'b0;
        bus_err_nxt_s  = 1'b0;
        if (busy_s) begin
            out_nxt_s = 32'h00000000;
        end else begin
            instr_nxt_s = MEM_instr;
            pc_nxt_s    = MEM_pc;
            if (abort_s) begin
                bus_err_nxt_s = 1'b1;
            end else if (misaligned_s) begin
                addr_err_nxt_s = 1'b1;
            end else if (is_load_s && done_s) begin
                out_nxt_s = load_extract(size_s, sign_s, MEM_alu[1:0], dm_rdata);
            end else if (is_mem_s) begin
                out_nxt_s = 32'h00000000;
            end else begin
                out_nxt_s = MEM_alu;
            end
        end
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MEM_out_WB   <= 32'h00000000;
            MEM_instr_WB <= 32'h00000000;
            MEM_pc_WB    <= 32'h00000000;
            addr_err_WB  <= 1'b0;
            bus_err_WB   <= 1'b0;
        end else begin
            MEM_out_WB   <= out_nxt_s;
            MEM_instr_WB <= instr_nxt_s;
            MEM_pc_WB    <= pc_nxt_s;
            addr_err_WB  <= addr_err_nxt_s;
            bus_err_WB   <= bus_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a byte-addressed memory model.
module tb_mem_stage;
    localparam int TO = 4;

    logic        clk, rst;
    logic [31:0] MEM_pc, MEM_instr, MEM_alu, MEM_rt;
    logic        dm_req, dm_we, dm_ack, busy, addr_err_WB, bus_err_WB;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, MEM_out_WB, MEM_instr_WB, MEM_pc_WB;
    logic [3:0]  dm_be;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] mem_b [256];

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .MEM_pc(MEM_pc), .MEM_instr(MEM_instr), .MEM_alu(MEM_alu),
        .MEM_rt(MEM_rt), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .busy(busy),
        .MEM_out_WB(MEM_out_WB), .MEM_instr_WB(MEM_instr_WB), .MEM_pc_WB(MEM_pc_WB),
        .addr_err_WB(addr_err_WB), .bus_err_WB(bus_err_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_wb(input logic [31:0] out, input logic [31:0] ins, input logic [31:0] pc,
                            input logic ae, input logic be);
        check("wb_out", MEM_out_WB, out);
        check("wb_instr", MEM_instr_WB, ins);
        check("wb_pc", MEM_pc_WB, pc);
        check("wb_addr_err", {31'd0, addr_err_WB}, {31'd0, ae});
        check("wb_bus_err", {31'd0, bus_err_WB}, {31'd0, be});
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int w;
        w = int'(a[7:0]) & 252;
        return {mem_b[w+3], mem_b[w+2], mem_b[w+1], mem_b[w]};
    endfunction

    // Called at a falling edge; applies one instruction and follows it to retirement.
    task automatic run_op(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] rt,
                          input logic [31:0] pc, input int lat);
        logic [5:0]  op;
        int          size;
        bit          ld, st, sgn, mis, fin;
        logic [31:0] val, exp_be, exp_wd;
        op = instr[31:26];
        ld = 0; st = 0; sgn = 0; size = 4;
        case (op)
            6'h23: ld = 1;
            6'h20: begin ld = 1; size = 1; sgn = 1; end
            6'h24: begin ld = 1; size = 1; end
            6'h21: begin ld = 1; size = 2; sgn = 1; end
            6'h25: begin ld = 1; size = 2; end
            6'h2B: st = 1;
            6'h28: begin st = 1; size = 1; end
            6'h29: begin st = 1; size = 2; end
            default: ;
        endcase
        mis = (ld || st) && ((alu % size) != 0);
        MEM_instr = instr; MEM_alu = alu; MEM_rt = rt; MEM_pc = pc;
        if (!(ld || st) || mis) begin
            dm_ack = 1'($urandom_range(0, 1));
            dm_rdata = $urandom;
            #2;
            check("no_req", {31'd0, dm_req}, 32'd0);
            check("no_busy", {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
            check_wb(mis ? 32'd0 : alu, instr, pc, mis, 1'b0);
            @(negedge clk);
        end else begin
            exp_be = (size == 4) ? 32'hF : (((size == 2) ? 32'h3 : 32'h1) << (alu % 4));
            exp_wd = (size == 4) ? rt : (size == 2) ? {2{rt[15:0]}} : {4{rt[7:0]}};
            val = 0;
            for (int i = 0; i < size; i++) val |= 32'(mem_b[(int'(alu[7:0]) + i) % 256]) << (8 * i);
            if (sgn && size == 1 && val[7]) val |= 32'hFFFFFF00;
            if (sgn && size == 2 && val[15]) val |= 32'hFFFF0000;
            fin = 0;
            for (int k = 0; k <= TO && !fin; k++) begin
                dm_ack = (k == lat);
                dm_rdata = (k == lat) ? mem_word(alu) : $urandom;
                #2;
                check("req", {31'd0, dm_req}, 32'd1);
                check("we", {31'd0, dm_we}, {31'd0, st});
                check("addr", dm_addr, alu & 32'hFFFFFFFC);
                check("be", {28'd0, dm_be}, exp_be);
                if (st) check("wdata", dm_wdata, exp_wd);
                check("busy", {31'd0, busy}, {31'd0, (k != lat) && (k != TO)});
                @(posedge clk); #1;
                if (k == lat) begin
                    if (st) for (int i = 0; i < size; i++) mem_b[(int'(alu[7:0]) + i) % 256] = 8'(rt >> (8 * i));
                    check_wb(st ? 32'd0 : val, instr, pc, 1'b0, 1'b0);
                    fin = 1;
                end else if (k == TO) begin
                    check_wb(32'd0, instr, pc, 1'b0, 1'b1);
                    fin = 1;
                end else begin
                    check_wb(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
                end
                @(negedge clk);
            end
        end
        dm_ack = 1'b0;
    endtask

    initial begin
        logic [5:0]  ops [10];
        logic [31:0] a;
        ops = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h2B, 6'h28, 6'h29, 6'h00, 6'h09};
        for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
        rst = 1'b0; dm_ack = 1'b0; dm_rdata = 32'd0;
        MEM_pc = 32'd0; MEM_instr = 32'd0; MEM_alu = 32'd0; MEM_rt = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, dm_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check_wb(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;

        run_op(32'h00851021, 32'h00001234, 32'd0, 32'h00400000, 0);
        mem_b[0] = 8'hBE; mem_b[1] = 8'hBA; mem_b[2] = 8'hFE; mem_b[3] = 8'hCA;
        run_op({6'h23, 26'h0}, 32'h00000100, 32'd0, 32'h00400004, 0);
        mem_b[0] = 8'h00; mem_b[1] = 8'h00; mem_b[2] = 8'h00; mem_b[3] = 8'h80;
        run_op({6'h20, 26'h0}, 32'h00000103, 32'd0, 32'h00400008, 2);
        run_op({6'h24, 26'h0}, 32'h00000103, 32'd0, 32'h0040000C, 2);
        run_op({6'h29, 26'h0}, 32'h00000202, 32'h0000ABCD, 32'h00400010, 1);
        run_op({6'h28, 26'h0}, 32'h00000201, 32'h00000055, 32'h00400014, 0);
        run_op({6'h23, 26'h0}, 32'h00000102, 32'd0, 32'h00400018, 0);
        run_op({6'h23, 26'h0}, 32'h00000040, 32'd0, 32'h0040001C, 99);
        run_op(32'h00000000, 32'h00000000, 32'd0, 32'h00000000, 0);

        // Reset while an access is outstanding.
        MEM_instr = {6'h23, 26'h0}; MEM_alu = 32'h00000080; MEM_pc = 32'h00400020;
        repeat (2) @(negedge clk);
        #2;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, dm_req}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_wb(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        MEM_instr = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        run_op({6'h2B, 26'h0}, 32'h00000080, 32'h13579BDF, 32'h00400024, 99);

        for (int n = 0; n < 250; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_op({ops[$urandom_range(0, 9)], 26'($urandom)}, a, $urandom, $urandom,
                   int'($urandom_range(0, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the MIPS core; sits directly downstream of EX.
- Consumes EX's registered outputs: ALU result/address, rt store data, instruction and PC.
- Performs loads/stores over a req/ack data-memory handshake, with byte/halfword lane steering and sign/zero extension.
- Stalls the front of the pipe while an access is outstanding; registers results into the MEM/WB pipeline register.

Parameters:
- TIMEOUT, 16, max cycles in WAIT without dm_ack before the access is aborted (range 2..255).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- MEM_pc  in  32  PC of instruction in MEM (from EX register)
- MEM_instr  in  32  instruction in MEM; 0 = bubble
- MEM_alu  in  32  EX result (address for lw/lh/lhu/lb/lbu/sw/sh/sb, else datapath result)
- MEM_rt  in  32  store data
- dm_req  out  1  memory request
- dm_we  out  1  1 = store
- dm_addr  out  32  word address, {MEM_alu[31:2],2'b00}
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-replicated store data
- dm_ack  in  1  memory completes current request this cycle
- dm_rdata  in  32  read word, valid when dm_ack=1
- busy  out  1  stall request to PC/IF/ID/EX: hold all inputs stable
- MEM_out_WB  out  32  result to WB (load data or pass-through MEM_alu)
- MEM_instr_WB  out  32  instruction to WB
- MEM_pc_WB  out  32  PC to WB
- addr_err_WB  out  1  misaligned access flag to WB
- bus_err_WB  out  1  timeout abort flag to WB

Behaviour:
- Reset (rst=0, async): state=IDLE, wait counter=0. All *_WB outputs are 0. dm_req=0 and busy=0, forced combinationally while rst=0.
- Decode:
  - is_load: opcode in {lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101}.
  - is_store: opcode in {sw 101011, sb 101000, sh 101001}.
  - is_mem = is_load | is_store.
- Alignment: misaligned when
  - lw/sw: MEM_alu[1:0]!=0
  - lh/lhu/sh: MEM_alu[0]!=0
  - byte ops: never misaligned
- Misaligned access: no request issued; completes in 1 cycle. WB receives instr/pc, MEM_out_WB=0, addr_err_WB=1.
- FSM states IDLE, WAIT:
  - IDLE: dm_req = is_mem & aligned.
    - dm_ack=1 same cycle: complete.
    - dm_ack=0: go WAIT, counter=1.
  - WAIT: dm_req=1; request fields are driven from the (held) inputs.
    - dm_ack=1: complete, go IDLE.
    - dm_ack=0 and counter==TIMEOUT: abort, go IDLE. WB gets instr/pc, MEM_out_WB=0, bus_err_WB=1.
    - Otherwise counter+1.
- busy = dm_req & ~dm_ack & ~abort. Upstream advances on the same edge that completes the access.
- MEM/WB register update each rising edge:
  - On completion, non-mem op, or misaligned access: load instr/pc/result/flags.
  - While busy=1: load bubble (all zeros); the instruction is never duplicated.
  - Non-mem op: MEM_out_WB=MEM_alu, 1-cycle latency, flags 0.
  - Store completion: MEM_out_WB=0.
- Store steering:
  - sw: be=1111, wdata=MEM_rt.
  - sh: wdata={2{MEM_rt[15:0]}}, be = addr[1] ? 1100 : 0011.
  - sb: wdata={4{MEM_rt[7:0]}}, be = 0001<<addr[1:0].
- Loads: dm_we=0, be as for the store of the same width.
- Load extraction is little-endian:
  - byte = dm_rdata[8*addr[1:0]+:8]; half = dm_rdata[16*addr[1]+:16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- dm_ack while dm_req=0 is ignored. Memory must not ack an aborted request later. dm_rdata is sampled only on accepted ack.
- Reset mid-WAIT: the FSM returns to IDLE immediately and the pending access is dropped.
- Bubble (instr=0) has opcode 0, so it is treated as a non-mem op: WB receives 0.

Test Plan:
- ALU pass-through: instr=addu-type, MEM_alu=0x1234 -> next edge MEM_out_WB=0x1234, dm_req never 1, busy=0.
- Zero-wait lw: MEM_alu=0x100, dm_ack=1 same cycle, dm_rdata=0xCAFEBABE -> dm_addr=0x100, be=1111, busy=0, next edge MEM_out_WB=0xCAFEBABE.
- 3-cycle lb:
  - Stimulus: MEM_alu=0x103, ack on 3rd request cycle, rdata=0x80000000.
  - Required: busy=1 for 2 cycles, WB gets zeros during those cycles, then MEM_out_WB=0xFFFFFF80.
  - Repeat with lbu -> 0x00000080.
- Stores:
  - sh at 0x202, rt=0x0000ABCD -> be=1100, wdata=0xABCDABCD, we=1.
  - sb at 0x201, rt=0x55 -> be=0010.
- Misaligned lw at 0x102 -> dm_req=0, next edge addr_err_WB=1, MEM_out_WB=0.
- Timeout and reset:
  - TIMEOUT=4, ack never arrives -> busy high 4 cycles, then bus_err_WB=1, FSM back in IDLE.
  - rst asserted in WAIT -> dm_req and busy drop immediately, all WB outputs 0.
